// File: rtl/cache_pkg.sv
// Shared cache refill definitions: AXI burst/response codes, geometry helpers, refill FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_pkg;

  // AXI4 burst type and response codes used by the refill engine
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Refill engine states; explicit 2-bit encoding keeps the legacy state values
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    AR       = 2'd1,
    DATA     = 2'd2,
    WAIT_CLR = 2'd3
  } refill_state_e;

  // Bytes carried by one data word / AXI beat
  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // Number of data beats needed to fill one cache line
  function automatic int beats(input int line_size_bits, input int data_width);
    return (1 << line_size_bits) / (data_width / 8);
  endfunction

endpackage

// File: rtl/cache_line_refill.sv
// AXI4 read-master line refill: one line-aligned INCR burst per miss, R beats streamed to the fill port.
// Latency: miss -> arvalid 1 cycle; accepted R beat -> fill beat 1 cycle (registered).
// Backpressure: AR held until arready; rready constant 1 in DATA (cache never stalls). Optional REFILL_ERR_CAPTURE_EN adds error capture.
module cache_line_refill
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_SIZE_BITS = 7,
  parameter int ID_WIDTH       = 4,
  parameter int AXI_ID         = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  // cache side
  input  logic                      miss,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data,
  output logic [DATA_WIDTH/8-1:0]   mem_wstb,
  output logic                      mem_data_valid,
  output logic                      mem_last,
  output logic                      busy,
  // AXI AR channel
  output logic [ID_WIDTH-1:0]       m_axi_arid,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [7:0]                m_axi_arlen,
  output logic [2:0]                m_axi_arsize,
  output logic [1:0]                m_axi_arburst,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  // AXI R channel
  input  logic [ID_WIDTH-1:0]       m_axi_rid,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rlast,
  input  logic                      m_axi_rvalid,
`ifdef REFILL_ERR_CAPTURE_EN
  input  logic                      err_clr,
  output logic                      refill_err,
  output logic [ADDR_WIDTH-1:0]     refill_err_addr,
`endif
  output logic                      m_axi_rready
);

  localparam int BPW   = bytes_per_word(DATA_WIDTH);
  localparam int BEATS = beats(LINE_SIZE_BITS, DATA_WIDTH);
  localparam int OFS   = $clog2(BPW);
  // one spare bit so the counter never wraps inside a line
  localparam int CW    = $clog2(BEATS) + 1;

  refill_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]    base_q, base_d;
  logic [ADDR_WIDTH-1:0]    araddr_q, araddr_d;
  logic                     arvalid_q, arvalid_d;
  logic                     rready_q, rready_d;
  logic [CW-1:0]            beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]    mem_data_q, mem_data_d;
  logic                     mem_valid_q, mem_valid_d;
  logic                     mem_last_q, mem_last_d;

  logic [ADDR_WIDTH-1:0]    line_base;
  logic [ADDR_WIDTH-1:0]    beat_addr;
  logic                     beat_fire;
  logic                     last_beat;

  assign line_base = {cpu_addr[ADDR_WIDTH-1:LINE_SIZE_BITS], {LINE_SIZE_BITS{1'b0}}};
  assign beat_addr = base_q + (ADDR_WIDTH'(beat_q) << OFS);
  // rready is only ever high in DATA, so this is the accepted-beat strobe
  assign beat_fire = m_axi_rvalid & rready_q;
  // the counter alone decides the final beat; rlast is not trusted for sequencing
  assign last_beat = (beat_q == CW'(BEATS - 1));

  // Next-state logic for the refill sequence and fill-port registers
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    araddr_d    = araddr_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    beat_d      = beat_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_valid_d = 1'b0;
    mem_last_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (miss) begin
          base_d    = line_base;
          araddr_d  = line_base;
          arvalid_d = 1'b1;
          beat_d    = '0;
          state_d   = AR;
        end
      end
      AR: begin
        // arvalid may only fall after the handshake
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (beat_fire) begin
          mem_valid_d = 1'b1;
          mem_data_d  = m_axi_rdata;
          mem_addr_d  = beat_addr;
          beat_d      = beat_q + CW'(1);
          if (last_beat) begin
            mem_last_d = 1'b1;
            rready_d   = 1'b0;
            state_d    = WAIT_CLR;
          end
        end
      end
      WAIT_CLR: begin
        // wait for the cache to drop its miss level so the stale level cannot retrigger
        if (!miss) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      beat_q      <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_valid_q <= 1'b0;
      mem_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      araddr_q    <= araddr_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      beat_q      <= beat_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_valid_q <= mem_valid_d;
      mem_last_q  <= mem_last_d;
    end
  end

  assign mem_addr       = mem_addr_q;
  assign mem_data       = mem_data_q;
  assign mem_wstb       = {(DATA_WIDTH/8){mem_valid_q}};
  assign mem_data_valid = mem_valid_q;
  assign mem_last       = mem_last_q;
  assign busy           = (state_q != IDLE);

  // burst shape is fixed for every refill
  assign m_axi_arid     = ID_WIDTH'(AXI_ID);
  assign m_axi_araddr   = araddr_q;
  assign m_axi_arlen    = 8'(BEATS - 1);
  assign m_axi_arsize   = 3'(OFS);
  assign m_axi_arburst  = BURST_INCR;
  assign m_axi_arvalid  = arvalid_q;
  assign m_axi_rready   = rready_q;

`ifdef REFILL_ERR_CAPTURE_EN
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  beat_err;

  assign beat_err = beat_fire & ((m_axi_rresp != RESP_OKAY) |
                                 (m_axi_rlast != last_beat) |
                                 (m_axi_rid != ID_WIDTH'(AXI_ID)));

  // Sticky error flag; keeps the first failing line base, a same-cycle set beats a clear
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_clr) begin
      err_d      = 1'b0;
      err_addr_d = '0;
    end
    if (beat_err) begin
      err_d = 1'b1;
      if (!err_q || err_clr) begin
        err_addr_d = base_q;
      end
    end
  end

  // Error capture registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign refill_err      = err_q;
  assign refill_err_addr = err_addr_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, cpu_addr[LINE_SIZE_BITS-1:0]};
`else
  // response status, rlast and rid carry no meaning without error capture
  logic unused_ok;
  assign unused_ok = &{1'b0, cpu_addr[LINE_SIZE_BITS-1:0], m_axi_rresp, m_axi_rlast, m_axi_rid};
`endif

endmodule

// File: tb/tb_cache_line_refill.sv
// Self-checking bench for cache_line_refill: randomized refills against a line/beat reference model.
// Latency: model expects arvalid 1 cycle after miss and each fill beat 1 cycle after its R handshake.
// Backpressure: bench stalls AR and gaps R; error-capture checks only when REFILL_ERR_CAPTURE_EN is defined.
module tb_cache_line_refill;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int IW     = 4;
  localparam int NBEATS = 32;   // 128-byte line / 4-byte words

  logic            clk = 1'b0;
  logic            reset_n;
  logic            miss;
  logic [AW-1:0]   cpu_addr;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic [DW/8-1:0] mem_wstb;
  logic            mem_data_valid;
  logic            mem_last;
  logic            busy;
  logic [IW-1:0]   m_axi_arid;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [2:0]      m_axi_arsize;
  logic [1:0]      m_axi_arburst;
  logic            m_axi_arvalid;
  logic            m_axi_arready;
  logic [IW-1:0]   m_axi_rid;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rresp;
  logic            m_axi_rlast;
  logic            m_axi_rvalid;
  logic            m_axi_rready;
`ifdef REFILL_ERR_CAPTURE_EN
  logic            err_clr;
  logic            refill_err;
  logic [AW-1:0]   refill_err_addr;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_line_refill dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .miss           (miss),
    .cpu_addr       (cpu_addr),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .mem_wstb       (mem_wstb),
    .mem_data_valid (mem_data_valid),
    .mem_last       (mem_last),
    .busy           (busy),
    .m_axi_arid     (m_axi_arid),
    .m_axi_araddr   (m_axi_araddr),
    .m_axi_arlen    (m_axi_arlen),
    .m_axi_arsize   (m_axi_arsize),
    .m_axi_arburst  (m_axi_arburst),
    .m_axi_arvalid  (m_axi_arvalid),
    .m_axi_arready  (m_axi_arready),
    .m_axi_rid      (m_axi_rid),
    .m_axi_rdata    (m_axi_rdata),
    .m_axi_rresp    (m_axi_rresp),
    .m_axi_rlast    (m_axi_rlast),
    .m_axi_rvalid   (m_axi_rvalid),
`ifdef REFILL_ERR_CAPTURE_EN
    .err_clr        (err_clr),
    .refill_err     (refill_err),
    .refill_err_addr(refill_err_addr),
`endif
    .m_axi_rready   (m_axi_rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // everything the engine drives must be quiet; burst-shape constants must hold
  task automatic chk_quiet(input string pfx);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_data"}, mem_data, 0);
    chk({pfx, "_mem_wstb"}, mem_wstb, 0);
    chk({pfx, "_mem_valid"}, mem_data_valid, 0);
    chk({pfx, "_mem_last"}, mem_last, 0);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_arvalid"}, m_axi_arvalid, 0);
    chk({pfx, "_araddr"}, m_axi_araddr, 0);
    chk({pfx, "_rready"}, m_axi_rready, 0);
    chk({pfx, "_arlen"}, m_axi_arlen, 31);
    chk({pfx, "_arsize"}, m_axi_arsize, 2);
    chk({pfx, "_arburst"}, m_axi_arburst, 1);
    chk({pfx, "_arid"}, m_axi_arid, 0);
`ifdef REFILL_ERR_CAPTURE_EN
    chk({pfx, "_refill_err"}, refill_err, 0);
    chk({pfx, "_refill_err_addr"}, refill_err_addr, 0);
`endif
  endtask

  // One refill seen from the cache and the interconnect. Entered and left at a negedge.
  // mode: 0 rvalid always, 1 repeating 1,0,0, 2 random. err_beat/abort_beat < 0 disable.
  task automatic run_refill(input logic [AW-1:0] addr, input int ar_delay, input int mode,
                            input int err_beat, input int hold, input int abort_beat);
    logic [AW-1:0] base;
    logic [DW-1:0] dq[$];
    logic [DW-1:0] exp_data;
    int  k_sent, k_recv, cyc;
    bit  pending, acc;
    base = (addr >> 7) << 7;
    miss = 1'b1;
    cpu_addr = addr;
    @(posedge clk); @(negedge clk);
    chk("ar_valid", m_axi_arvalid, 1);
    chk("ar_addr", m_axi_araddr, base);
    chk("ar_len", m_axi_arlen, 31);
    chk("ar_size", m_axi_arsize, 2);
    chk("ar_busy", busy, 1);
    for (int i = 0; i < ar_delay; i++) begin
      chk("ar_no_early_rready", m_axi_rready, 0);
      @(posedge clk); @(negedge clk);
      chk("ar_hold_valid", m_axi_arvalid, 1);
      chk("ar_hold_addr", m_axi_araddr, base);
    end
    m_axi_arready = 1'b1;
    @(posedge clk); @(negedge clk);
    m_axi_arready = 1'b0;
    chk("ar_drop_after_hs", m_axi_arvalid, 0);

    k_sent = 0; k_recv = 0; pending = 0; cyc = 0;
    while (cyc < 400) begin
      chk("fill_valid", mem_data_valid, pending);
      if (pending) begin
        exp_data = dq.pop_front();
        chk("fill_data", mem_data, exp_data);
        chk("fill_addr", mem_addr, base + AW'(k_recv * 4));
        chk("fill_wstb", mem_wstb, 4'hf);
        chk("fill_last", mem_last, (k_recv == NBEATS - 1) ? 1 : 0);
        k_recv++;
      end else begin
        chk("fill_last_idle", mem_last, 0);
      end
      if (k_recv == NBEATS) begin
        chk("rready_drop", m_axi_rready, 0);
        break;
      end
      if (abort_beat >= 0 && k_sent == abort_beat) begin
        reset_n = 1'b0;
        miss = 1'b0;
        m_axi_rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
        chk_quiet("rst_mid");
        reset_n = 1'b1;
        return;
      end
      if (k_sent < NBEATS) begin
        chk("rready_high", m_axi_rready, 1);
        case (mode)
          0: m_axi_rvalid = 1'b1;
          1: m_axi_rvalid = (cyc % 3 == 0);
          default: m_axi_rvalid = 1'($urandom_range(0, 1));
        endcase
        m_axi_rdata = $urandom;
        m_axi_rlast = (k_sent == NBEATS - 1);
        m_axi_rresp = (k_sent == err_beat) ? 2'b10 : 2'b00;
        acc = m_axi_rvalid;
      end else begin
        m_axi_rvalid = 1'b0;
        acc = 1'b0;
      end
      if (acc) begin
        dq.push_back(m_axi_rdata);
        k_sent++;
      end
      pending = acc;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    chk("beats_filled", k_recv, NBEATS);
    m_axi_rvalid = 1'b0;
    m_axi_rlast = 1'b0;
    m_axi_rresp = 2'b00;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      chk("stale_no_arvalid", m_axi_arvalid, 0);
      chk("stale_busy", busy, 1);
      chk("stale_no_fill", mem_data_valid, 0);
    end
    miss = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_arvalid", m_axi_arvalid, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    miss = 1'b0;
    cpu_addr = '0;
    m_axi_arready = 1'b0;
    m_axi_rid = '0;
    m_axi_rdata = '0;
    m_axi_rresp = 2'b00;
    m_axi_rlast = 1'b0;
    m_axi_rvalid = 1'b0;
`ifdef REFILL_ERR_CAPTURE_EN
    err_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset");
    reset_n = 1'b1;

    // clean refill, everything immediate
    run_refill(32'h0000_1234, 0, 0, -1, 0, -1);
    // AR back-pressure for 5 cycles with random R gaps
    run_refill($urandom, 5, 2, -1, 0, -1);
    // R gaps 1,0,0,1 ...
    run_refill($urandom, 0, 1, -1, 0, -1);
    // stale miss held one cycle after mem_last, then a new miss
    run_refill($urandom, 1, 0, -1, 1, -1);
    run_refill($urandom, 0, 0, -1, 0, -1);
    // reset at beat 10, then a fresh refill from beat 0
    run_refill($urandom, 0, 0, -1, 0, 10);
    run_refill($urandom, 2, 2, -1, 0, -1);

    // error response on beat 3 of line 0x4000: fill still completes
    run_refill(32'h0000_4000, 0, 0, 3, 0, -1);
`ifdef REFILL_ERR_CAPTURE_EN
    chk("err_set", refill_err, 1);
    chk("err_addr", refill_err_addr, 32'h0000_4000);
    err_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", refill_err, 0);
    chk("err_addr_cleared", refill_err_addr, 0);
`endif

    for (int n = 0; n < 3; n++) begin
      run_refill($urandom, $urandom_range(0, 3), 2, -1, $urandom_range(0, 2), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
